// File: rtl/hazard3_pmp_loader.sv
// Boot-time PMP programmer: walks a region table and writes
// pmpaddrN then pmpcfgN, reading each cfg byte back to confirm it.
module hazard3_pmp_loader #(
  parameter int W_DATA      = 32,
  parameter int W_TADDR     = 8,
  parameter int PMP_REGIONS = 16,
  parameter int TABLE_BASE  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [3:0]         err_index,
  output logic               tbl_req,
  output logic [W_TADDR-1:0] tbl_addr,
  input  logic               tbl_rvalid,
  input  logic [31:0]        tbl_rdata,
  output logic [11:0]        cfg_addr,
  output logic               cfg_wen,
  output logic [W_DATA-1:0]  cfg_wdata,
  input  logic [W_DATA-1:0]  cfg_rdata
);

  typedef enum logic [2:0] {
    IDLE, FETCH0, FETCH1, CHECKIDX,
    WR_ADDR, RD_CFG, WR_CFG, VERIFY
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        cnt, cnt_nxt;
  logic [W_DATA-1:0] word0;
  logic [W_DATA-1:0] cfg_word;
  logic [7:0]        cfg_byte;
  logic [3:0]        idx;
  logic              last;
  logic              err_set;
  logic              err_clr;

  logic [W_TADDR-1:0] ent_addr;
  logic [4:0]         lane;
  logic [7:0]         rd_byte;
  logic               match;
  logic [W_DATA-1:0]  merged;
  logic [11:0]        cfg_csr;

  logic unused_tbl;
  assign unused_tbl = ^tbl_rdata[30:12];

  assign ent_addr = W_TADDR'(TABLE_BASE)
                  + W_TADDR'({cnt, 1'b0});
  assign lane     = {idx[1:0], 3'b000};
  assign rd_byte  = cfg_rdata[lane +: 8];
  // WPRI bits 6:5 always read as zero
  assign match    = (rd_byte & 8'h9f)
                 == (cfg_byte & 8'h9f);
  assign cfg_csr  = 12'h3a0 + {10'h0, idx[3:2]};
  assign busy     = (state != IDLE);

  always_comb begin
    merged = cfg_word;
    merged[lane +: 8] = cfg_byte;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tbl_req   = 1'b0;
    tbl_addr  = '0;
    cfg_addr  = '0;
    cfg_wen   = 1'b0;
    cfg_wdata = '0;
    done      = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          err_clr   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = FETCH0;
        end
      end
      FETCH0: begin
        tbl_req  = 1'b1;
        tbl_addr = ent_addr;
        if (tbl_rvalid) state_nxt = FETCH1;
      end
      FETCH1: begin
        tbl_req  = 1'b1;
        tbl_addr = ent_addr + W_TADDR'(1);
        if (tbl_rvalid) state_nxt = CHECKIDX;
      end
      CHECKIDX: begin
        if ({1'b0, idx} >= 5'(PMP_REGIONS)) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WR_ADDR;
        end
      end
      WR_ADDR: begin
        cfg_addr  = 12'h3b0 + {8'h0, idx};
        cfg_wen   = 1'b1;
        cfg_wdata = word0;
        state_nxt = RD_CFG;
      end
      RD_CFG: begin
        cfg_addr  = cfg_csr;
        state_nxt = WR_CFG;
      end
      WR_CFG: begin
        cfg_addr  = cfg_csr;
        cfg_wen   = 1'b1;
        cfg_wdata = merged;
        state_nxt = VERIFY;
      end
      VERIFY: begin
        cfg_addr  = cfg_csr;
        if (!match) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else if (last ||
            cnt == 4'(PMP_REGIONS - 1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = cnt + 4'd1;
          state_nxt = FETCH0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      err       <= 1'b0;
      err_index <= '0;
      word0     <= '0;
      cfg_word  <= '0;
      cfg_byte  <= '0;
      idx       <= '0;
      last      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (err_clr) err <= 1'b0;
      if (err_set) begin
        err       <= 1'b1;
        err_index <= idx;
      end
      if (state == FETCH0 && tbl_rvalid)
        word0 <= W_DATA'(tbl_rdata);
      if (state == FETCH1 && tbl_rvalid) begin
        cfg_byte <= tbl_rdata[7:0];
        idx      <= tbl_rdata[11:8];
        last     <= tbl_rdata[31];
      end
      if (state == RD_CFG) cfg_word <= cfg_rdata;
    end
  end

endmodule

// File: tb/tb_hazard3_pmp_loader.sv
// Scoreboard bench for hazard3_pmp_loader with a table memory
// model and a small behavioural PMP (lock, TOR->OFF remap).
module tb_hazard3_pmp_loader;

  localparam int NREG = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [3:0]  err_index;
  logic        tbl_req;
  logic [7:0]  tbl_addr;
  logic        tbl_rvalid = 1'b0;
  logic [31:0] tbl_rdata;
  logic [11:0] cfg_addr;
  logic        cfg_wen;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;

  always #5 clk = ~clk;

  hazard3_pmp_loader #(
    .W_DATA(32), .W_TADDR(8),
    .PMP_REGIONS(NREG), .TABLE_BASE(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .err(err),
    .err_index(err_index),
    .tbl_req(tbl_req), .tbl_addr(tbl_addr),
    .tbl_rvalid(tbl_rvalid), .tbl_rdata(tbl_rdata),
    .cfg_addr(cfg_addr), .cfg_wen(cfg_wen),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // table memory with per-request latency 1..maxdly
  logic [31:0] mem [256];
  logic [7:0]  raddr = '0;
  logic        pend = 1'b0;
  int          cnt = 0;
  int          dly = 1;
  int          maxdly = 1;

  assign tbl_rdata = mem[raddr];

  always @(posedge clk) begin
    dly <= $urandom_range(1, maxdly);
    if (tbl_rvalid) begin
      tbl_rvalid <= 1'b0;
    end else if (pend) begin
      if (cnt == 0) begin
        tbl_rvalid <= 1'b1;
        pend <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end else if (tbl_req) begin
      raddr <= tbl_addr;
      if (dly == 1) begin
        tbl_rvalid <= 1'b1;
      end else begin
        pend <= 1'b1;
        cnt  <= dly - 2;
      end
    end
  end

  // PMP model
  logic [7:0]  pcfg [16];
  logic [31:0] paddr [16];
  logic        pmp_clr = 1'b1;

  function automatic logic [7:0] legal(logic [7:0] v);
    logic [7:0] r;
    r = v & 8'h9f;
    if (r[4:3] == 2'b01) r[4:3] = 2'b00;
    return r;
  endfunction

  always @(posedge clk) begin
    if (pmp_clr) begin
      for (int i = 0; i < 16; i++) begin
        pcfg[i]  <= (i == 4) ? 8'h11 : 8'h00;
        paddr[i] <= '0;
      end
    end else if (cfg_wen) begin
      if (cfg_addr[11:4] == 8'h3b &&
          !pcfg[cfg_addr[3:0]][7])
        paddr[cfg_addr[3:0]] <= cfg_wdata;
      if (cfg_addr[11:2] == 10'h0e8)
        for (int b = 0; b < 4; b++)
          if (!pcfg[{cfg_addr[1:0], 2'(b)}][7])
            pcfg[{cfg_addr[1:0], 2'(b)}] <=
              legal(cfg_wdata[8*b +: 8]);
    end
  end

  always_comb begin
    cfg_rdata = '0;
    if (cfg_addr[11:2] == 10'h0e8)
      cfg_rdata = {pcfg[{cfg_addr[1:0], 2'd3}],
                   pcfg[{cfg_addr[1:0], 2'd2}],
                   pcfg[{cfg_addr[1:0], 2'd1}],
                   pcfg[{cfg_addr[1:0], 2'd0}]};
    else if (cfg_addr[11:4] == 8'h3b)
      cfg_rdata = paddr[cfg_addr[3:0]];
  end

  // scoreboard: kind 0 = cfg write, 1 = done, 2 = err
  typedef struct packed {
    logic [1:0]  kind;
    logic [11:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t sbq[$];
  logic err_q = 1'b0;

  task automatic push(logic [1:0] k, logic [11:0] a,
                      logic [31:0] d);
    sbq.push_back('{kind: k, a: a, d: d});
  endtask

  task automatic pop_chk(string nm, ev_t act);
    ev_t e;
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got unexpected %h expected none",
               nm, act);
    end else begin
      e = sbq.pop_front();
      chk(nm, 64'(act), 64'(e));
    end
  endtask

  always @(negedge clk) begin
    if (cfg_wen)
      pop_chk("cfg_write", {2'd0, cfg_addr, cfg_wdata});
    if (done)
      pop_chk("done", {2'd1, 12'h0, 32'h0});
    if (err && !err_q)
      pop_chk("err", {2'd2, 12'h0, 28'h0, err_index});
    err_q <= err;
  end

  task automatic set_ent(int k, logic [31:0] w0,
                         logic [31:0] w1);
    mem[2*k]   = w0;
    mem[2*k+1] = w1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_end(string nm, output int cyc);
    bit ok;
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cyc++;
      if (done || err) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 64'(ok), 64'd1);
  endtask

  int cyc;
  bit hit;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        {busy, done, err, err_index, tbl_req, tbl_addr,
         cfg_wen, cfg_addr, cfg_wdata}, 64'd0);
    rst = 1'b0;
    pmp_clr = 1'b0;

    // single locked NAPOT entry, latency check
    set_ent(0, 32'h0000_1fff, 32'h8000_009f);
    push(0, 12'h3b0, 32'h0000_1fff);
    push(0, 12'h3a0, 32'h0000_009f);
    push(1, 0, 0);
    do_start();
    wait_end("t1_finish", cyc);
    chk("t1_latency", 64'(cyc), 64'd9);
    chk("t1_err", 64'(err), 64'd0);
    @(negedge clk);
    chk("t1_busy_low", 64'(busy), 64'd0);

    // three entries in pmpcfg1, start while busy ignored
    set_ent(0, 32'h0000_0100, 32'h0000_051b);
    set_ent(1, 32'h0000_0200, 32'h0000_0619);
    set_ent(2, 32'h0000_0300, 32'h8000_0718);
    push(0, 12'h3b5, 32'h0000_0100);
    push(0, 12'h3a1, 32'h0000_1b11);
    push(0, 12'h3b6, 32'h0000_0200);
    push(0, 12'h3a1, 32'h0019_1b11);
    push(0, 12'h3b7, 32'h0000_0300);
    push(0, 12'h3a1, 32'h1819_1b11);
    push(1, 0, 0);
    do_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_end("t2_finish", cyc);
    chk("t2_err", 64'(err), 64'd0);
    @(negedge clk);
    chk("t2_pmpcfg1",
        {pcfg[7], pcfg[6], pcfg[5], pcfg[4]},
        64'h1819_1b11);
    chk("t2_sb_empty", 64'(sbq.size()), 64'd0);

    // TOR remapped to OFF -> mismatch on region 2
    set_ent(0, 32'h0000_0400, 32'h0000_020f);
    push(0, 12'h3b2, 32'h0000_0400);
    push(0, 12'h3a0, 32'h000f_009f);
    push(2, 0, 32'd2);
    do_start();
    wait_end("t3_finish", cyc);
    @(negedge clk);
    chk("t3_err", {busy, err, err_index}, {2'b01, 4'd2});
    chk("t3_sb_empty", 64'(sbq.size()), 64'd0);

    // region 0 locked from the first walk
    set_ent(0, 32'h0000_0500, 32'h8000_001f);
    push(0, 12'h3b0, 32'h0000_0500);
    push(0, 12'h3a0, 32'h0007_001f);
    push(2, 0, 32'd0);
    do_start();
    wait_end("t4_finish", cyc);
    @(negedge clk);
    chk("t4_err", {busy, err, err_index}, {2'b01, 4'd0});
    chk("t4_sb_empty", 64'(sbq.size()), 64'd0);

    // index beyond implemented regions: no cfg writes
    set_ent(0, 32'h0000_0600, 32'h8000_0f11);
    push(2, 0, 32'd15);
    do_start();
    wait_end("t5_finish", cyc);
    chk("t5_latency", 64'(cyc), 64'd6);
    @(negedge clk);
    chk("t5_err", {busy, err, err_index}, {2'b01, 4'hf});
    chk("t5_sb_empty", 64'(sbq.size()), 64'd0);

    // random table latency, reset during WR_CFG, rerun
    maxdly = 4;
    set_ent(0, 32'h0000_0700, 32'h0000_0301);
    set_ent(1, 32'h0000_0800, 32'h8000_0403);
    push(0, 12'h3b3, 32'h0000_0700);
    push(0, 12'h3a0, 32'h0107_009f);
    do_start();
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cfg_wen && cfg_addr == 12'h3a0) begin
        rst = 1'b1;
        hit = 1'b1;
        break;
      end
    end
    chk("t6_reach_wrcfg", 64'(hit), 64'd1);
    @(negedge clk);
    chk("t6_reset_outs",
        {busy, done, err, tbl_req, cfg_wen, cfg_addr},
        64'd0);
    rst = 1'b0;
    chk("t6_sb_empty_rst", 64'(sbq.size()), 64'd0);
    chk("t6_pmp_kept", 64'(pcfg[3]), 64'h01);
    push(0, 12'h3b3, 32'h0000_0700);
    push(0, 12'h3a0, 32'h0107_009f);
    push(0, 12'h3b4, 32'h0000_0800);
    push(0, 12'h3a1, 32'h1819_1b03);
    push(1, 0, 0);
    do_start();
    wait_end("t6_finish", cyc);
    chk("t6_err", 64'(err), 64'd0);
    @(negedge clk);
    chk("t6_sb_empty", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
